// File: rtl/vram_pkg.sv
// Shared types and constants for the text-VRAM access controller and its block engine.
package vram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CPU_ACC = 3'd1,
    ST_ENG_RD  = 3'd2,
    ST_ENG_WR  = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  localparam logic OP_FILL   = 1'b0;
  localparam logic OP_SCROLL = 1'b1;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 25;
  localparam int AW_DEF   = 11;

  function automatic int calc_n(input int cols, input int rows);
    return cols * rows;
  endfunction

endpackage

// File: rtl/vram_blk_engine.sv
// Block engine for full-screen FILL / SCROLL-UP; presents one VRAM step at a time
// (request, direction, address, data) and advances on read/write completions.
module vram_blk_engine
  import vram_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op,
  input  logic [7:0]    fill_char,
  input  logic          rd_done,
  input  logic          wr_done,
  input  logic [7:0]    rd_data,
  output logic          req,
  output logic          req_wr,
  output logic [AW-1:0] req_addr,
  output logic [7:0]    req_data,
  output logic          busy,
  output logic          done
);

  localparam int            N           = calc_n(COLS, ROWS);
  localparam logic [AW-1:0] LAST_IDX    = AW'(N - 1);
  localparam logic [AW-1:0] BLANK_START = AW'(N - COLS);
  localparam logic [AW-1:0] ROW_STRIDE  = AW'(COLS);

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          op_q, op_d;
  logic [7:0]    fill_q, fill_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          have_q, have_d;
  logic [7:0]    data_q, data_d;
  logic          blank_zone;

  // Cells written with the fill character: every FILL cell and the last row of a SCROLL.
  assign blank_zone = (op_q == OP_FILL) || (idx_q >= BLANK_START);
  assign req        = busy_q;
  assign req_wr     = blank_zone | have_q;
  assign req_addr   = req_wr ? idx_q : (idx_q + ROW_STRIDE);
  assign req_data   = blank_zone ? fill_q : data_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Next-state: command acceptance, read-data latch, index advance and completion.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    op_d   = op_q;
    fill_d = fill_q;
    idx_d  = idx_q;
    have_d = have_q;
    data_d = data_q;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        op_d   = op;
        fill_d = fill_char;
        idx_d  = {AW{1'b0}};
        have_d = 1'b0;
      end else begin
        busy_d = 1'b0;
      end
    end else if (rd_done) begin
      data_d = rd_data;
      have_d = 1'b1;
    end else if (wr_done) begin
      have_d = 1'b0;
      if (idx_q == LAST_IDX) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + AW'(1);
      end
    end else begin
      have_d = have_q;
    end
  end

  // Engine state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      op_q   <= OP_FILL;
      fill_q <= 8'h00;
      idx_q  <= {AW{1'b0}};
      have_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      op_q   <= op_d;
      fill_q <= fill_d;
      idx_q  <= idx_d;
      have_q <= have_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/vram_access_ctrl.sv
// Arbiter/sequencer sharing the VRAM CPU port between the CPU bus and the block engine.
// Optional macro VRAM_ARB_FAIR_EN selects round-robin instead of strict CPU priority.
module vram_access_ctrl
  import vram_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CPU_CS,
  input  logic          CPU_WR,
  input  logic [AW-1:0] CPU_A,
  input  logic [7:0]    CPU_DIN,
  output logic [7:0]    CPU_DOUT,
  output logic          CPU_WAIT,
  input  logic          START,
  input  logic          OP,
  input  logic [7:0]    FILL_CHAR,
  output logic          BUSY,
  output logic          DONE,
  output logic          VRAM_CS,
  output logic          VRAM_WR,
  output logic [AW-1:0] VRAM_A,
  output logic [7:0]    VRAM_DIN,
  input  logic [7:0]    VRAM_DOUT,
  input  logic          VRAM_WAIT
);

  state_t        state_q, state_d;
  logic          vram_cs_q, vram_cs_d;
  logic          vram_wr_q, vram_wr_d;
  logic [AW-1:0] vram_a_q, vram_a_d;
  logic [7:0]    vram_din_q, vram_din_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          ack_q, ack_d;
  logic          eng_req, eng_wr, eng_rd_done, eng_wr_done;
  logic [AW-1:0] eng_addr;
  logic [7:0]    eng_data;
  logic          cpu_pend, grant_cpu, xfer_done;

  vram_blk_engine #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_eng (
    .clk      (CLK),
    .reset    (RESET),
    .start    (START),
    .op       (OP),
    .fill_char(FILL_CHAR),
    .rd_done  (eng_rd_done),
    .wr_done  (eng_wr_done),
    .rd_data  (VRAM_DOUT),
    .req      (eng_req),
    .req_wr   (eng_wr),
    .req_addr (eng_addr),
    .req_data (eng_data),
    .busy     (BUSY),
    .done     (DONE)
  );

  assign cpu_pend  = CPU_CS & ~ack_q;
  assign xfer_done = vram_cs_q & ~VRAM_WAIT;
  assign CPU_WAIT  = CPU_CS & ~ack_q;

`ifdef VRAM_ARB_FAIR_EN
  logic last_cpu_q, last_cpu_d;
  // CPU yields to a waiting engine step only if it was served last.
  assign grant_cpu = cpu_pend & (~eng_req | ~last_cpu_q);
`else
  assign grant_cpu = cpu_pend;
`endif

  // Next-state: grant in IDLE, wait for completion, then a mandatory idle GAP cycle.
  always_comb begin
    state_d     = state_q;
    vram_cs_d   = vram_cs_q;
    vram_wr_d   = vram_wr_q;
    vram_a_d    = vram_a_q;
    vram_din_d  = vram_din_q;
    cpu_dout_d  = cpu_dout_q;
    ack_d       = ack_q & CPU_CS;
    eng_rd_done = 1'b0;
    eng_wr_done = 1'b0;
`ifdef VRAM_ARB_FAIR_EN
    last_cpu_d  = last_cpu_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_cpu) begin
          state_d    = ST_CPU_ACC;
          vram_cs_d  = 1'b1;
          vram_wr_d  = CPU_WR;
          vram_a_d   = CPU_A;
          vram_din_d = CPU_DIN;
`ifdef VRAM_ARB_FAIR_EN
          last_cpu_d = 1'b1;
`endif
        end else if (eng_req) begin
          state_d    = eng_wr ? ST_ENG_WR : ST_ENG_RD;
          vram_cs_d  = 1'b1;
          vram_wr_d  = eng_wr;
          vram_a_d   = eng_addr;
          vram_din_d = eng_data;
`ifdef VRAM_ARB_FAIR_EN
          last_cpu_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CPU_ACC: begin
        if (xfer_done) begin
          state_d   = ST_GAP;
          vram_cs_d = 1'b0;
          vram_wr_d = 1'b0;
          // An abandoned request still finishes on the VRAM side; its result is dropped.
          if (CPU_CS) begin
            cpu_dout_d = vram_wr_q ? vram_din_q : VRAM_DOUT;
            ack_d      = 1'b1;
          end else begin
            ack_d = 1'b0;
          end
        end else begin
          state_d = ST_CPU_ACC;
        end
      end
      ST_ENG_RD: begin
        if (xfer_done) begin
          state_d     = ST_GAP;
          vram_cs_d   = 1'b0;
          eng_rd_done = 1'b1;
        end else begin
          state_d = ST_ENG_RD;
        end
      end
      ST_ENG_WR: begin
        if (xfer_done) begin
          state_d     = ST_GAP;
          vram_cs_d   = 1'b0;
          vram_wr_d   = 1'b0;
          eng_wr_done = 1'b1;
        end else begin
          state_d = ST_ENG_WR;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: begin
        state_d   = ST_IDLE;
        vram_cs_d = 1'b0;
        vram_wr_d = 1'b0;
      end
    endcase
  end

  // Arbiter FSM and registered VRAM/CPU outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      vram_cs_q  <= 1'b0;
      vram_wr_q  <= 1'b0;
      vram_a_q   <= {AW{1'b0}};
      vram_din_q <= 8'h00;
      cpu_dout_q <= 8'hFF;
      ack_q      <= 1'b0;
`ifdef VRAM_ARB_FAIR_EN
      last_cpu_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      vram_cs_q  <= vram_cs_d;
      vram_wr_q  <= vram_wr_d;
      vram_a_q   <= vram_a_d;
      vram_din_q <= vram_din_d;
      cpu_dout_q <= cpu_dout_d;
      ack_q      <= ack_d;
`ifdef VRAM_ARB_FAIR_EN
      last_cpu_q <= last_cpu_d;
`endif
    end
  end

  assign VRAM_CS  = vram_cs_q;
  assign VRAM_WR  = vram_wr_q;
  assign VRAM_A   = vram_a_q;
  assign VRAM_DIN = vram_din_q;
  assign CPU_DOUT = cpu_dout_q;

endmodule

// File: tb/tb_vram_access_ctrl.sv
// Scoreboard bench for vram_access_ctrl: VRAM behavioural model, screen reference model,
// random CPU traffic, FILL / SCROLL / reset-abort scenarios.
module tb_vram_access_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 25;
  localparam int AW   = 11;
  localparam int N    = COLS * ROWS;

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic          CPU_CS = 1'b0, CPU_WR = 1'b0;
  logic [AW-1:0] CPU_A = '0;
  logic [7:0]    CPU_DIN = 8'h00;
  logic [7:0]    CPU_DOUT;
  logic          CPU_WAIT;
  logic          START = 1'b0, OP = 1'b0;
  logic [7:0]    FILL_CHAR = 8'h00;
  logic          BUSY, DONE;
  logic          VRAM_CS, VRAM_WR, VRAM_WAIT;
  logic [AW-1:0] VRAM_A;
  logic [7:0]    VRAM_DIN, VRAM_DOUT;

  always #5 clk = ~clk;

  vram_access_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .CLK(clk), .RESET(RESET),
    .CPU_CS(CPU_CS), .CPU_WR(CPU_WR), .CPU_A(CPU_A), .CPU_DIN(CPU_DIN),
    .CPU_DOUT(CPU_DOUT), .CPU_WAIT(CPU_WAIT),
    .START(START), .OP(OP), .FILL_CHAR(FILL_CHAR), .BUSY(BUSY), .DONE(DONE),
    .VRAM_CS(VRAM_CS), .VRAM_WR(VRAM_WR), .VRAM_A(VRAM_A), .VRAM_DIN(VRAM_DIN),
    .VRAM_DOUT(VRAM_DOUT), .VRAM_WAIT(VRAM_WAIT)
  );

  // VRAM model: one wait cycle (execute), then a completion cycle.
  logic [7:0] mem [0:2047];
  logic       phase = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic       init_mem = 1'b0;
  assign VRAM_WAIT = VRAM_CS & ~phase;
  assign VRAM_DOUT = rdata;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 2048; k++) mem[k] <= 8'(k);
    end else if (VRAM_CS && !phase) begin
      if (VRAM_WR) mem[VRAM_A] <= VRAM_DIN;
      else rdata <= mem[VRAM_A];
    end
    phase <= VRAM_CS && !phase;
  end

  typedef struct packed { logic [7:0] a; logic [7:0] b; } exp_t;
  exp_t       sbq[$];
  int         done_pending = 0;
  int         done_cnt = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] model [0:2047];
  logic [7:0] newm  [0:2047];
  logic       mon_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: completed CPU accesses and DONE pulses are checked against the scoreboard.
  always @(negedge clk) begin
    if (CPU_CS && !CPU_WAIT) begin
      if (!mon_seen) begin
        exp_t e;
        mon_seen = 1'b1;
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL cpu_unexpected: got %0h with empty scoreboard", CPU_DOUT);
        end else begin
          e = sbq.pop_front();
          if (CPU_DOUT !== e.a && CPU_DOUT !== e.b) begin
            miscompares++;
            $display("FAIL cpu_dout: got %0h expected %0h or %0h", CPU_DOUT, e.a, e.b);
          end
        end
      end
    end else if (!CPU_CS) begin
      mon_seen = 1'b0;
    end
    if (DONE) begin
      vectors++;
      if (done_pending == 0) begin
        miscompares++;
        $display("FAIL done_unexpected: got DONE=1 expected 0");
      end else begin
        done_pending--;
        done_cnt++;
        if (BUSY !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_at_done: got %0b expected 0", BUSY);
        end
      end
    end
  end

  task automatic cpu_acc(input logic wr, input logic [AW-1:0] a, input logic [7:0] d,
                         input logic [7:0] ea, input logic [7:0] eb, output int lat);
    exp_t e;
    @(posedge clk); #1;
    CPU_CS = 1'b1; CPU_WR = wr; CPU_A = a; CPU_DIN = d;
    e.a = ea; e.b = eb;
    sbq.push_back(e);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (CPU_WAIT && lat < 60);
    if (CPU_WAIT) begin
      chk("cpu_wait_timeout", 32'(lat), 32'd0);
      sbq.delete();
    end
    @(posedge clk); #1;
    CPU_CS = 1'b0;
  endtask

  task automatic start_op(input logic op, input logic [7:0] ch);
    @(posedge clk); #1;
    START = 1'b1; OP = op; FILL_CHAR = ch;
    done_pending++;
    @(posedge clk); #1;
    START = 1'b0;
    chk("busy_after_start", 32'(BUSY), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int c0 = done_cnt;
    int n = 0;
    while (done_cnt == c0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt - c0), 32'd1);
  endtask

  task automatic chk_region(input string nm, input int lo, input int hi, input logic [7:0] v);
    int errs = 0;
    int first = -1;
    for (int k = lo; k <= hi; k++) begin
      if (mem[k] !== v) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL %s: %0d cells wrong, first cell %0d got %0h expected %0h",
               nm, errs, first, mem[first], v);
    end
  endtask

  task automatic chk_model(input string nm);
    int errs = 0;
    int first = -1;
    for (int k = 0; k < 2048; k++) begin
      if (mem[k] !== model[k]) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL %s: %0d cells wrong, first cell %0d got %0h expected %0h",
               nm, errs, first, mem[first], model[first]);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [AW-1:0] a;
    logic [7:0] d;
    int eng_cycles;

    init_mem = 1'b1;
    for (int k = 0; k < 2048; k++) model[k] = 8'(k);
    repeat (3) @(posedge clk);
    #1;
    init_mem = 1'b0;
    RESET = 1'b0;
    chk("rst_cpu_dout", 32'(CPU_DOUT), 32'hFF);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_vram_cs", 32'(VRAM_CS), 32'd0);

    // Directed write/read, then random traffic with idle engine (3-cycle latency).
    cpu_acc(1'b1, 11'h010, 8'h41, 8'h41, 8'h41, lat);
    model[16] = 8'h41;
    chk("wr_latency", 32'(lat), 32'd3);
    cpu_acc(1'b0, 11'h010, 8'h00, 8'h41, 8'h41, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    for (int t = 0; t < 12; t++) begin
      a = 11'($urandom_range(0, 2047));
      d = 8'($urandom);
      cpu_acc(1'b1, a, d, d, d, lat);
      model[a] = d;
      a = 11'($urandom_range(0, 2047));
      cpu_acc(1'b0, a, 8'h00, model[a], model[a], lat);
      chk("rand_latency", 32'(lat), 32'd3);
    end
    chk_model("cpu_traffic_screen");

    // FILL, with an ignored START issued mid-operation.
    start_op(1'b0, 8'h20);
    repeat (50) @(posedge clk);
    #1;
    START = 1'b1; OP = 1'b1; FILL_CHAR = 8'h99;
    @(posedge clk); #1;
    START = 1'b0;
    wait_done(20000);
    for (int k = 0; k < N; k++) model[k] = 8'h20;
    chk_region("fill_cells", 0, N - 1, 8'h20);
    chk("fill_cell_2000", 32'(mem[2000]), 32'(model[2000]));
    chk_model("fill_screen");

    // SCROLL over a k[7:0] preload, with concurrent CPU reads.
    @(posedge clk); #1;
    init_mem = 1'b1;
    @(posedge clk); #1;
    init_mem = 1'b0;
    for (int k = 0; k < 2048; k++) model[k] = 8'(k);
    for (int k = 0; k < 2048; k++) newm[k] = model[k];
    for (int k = 0; k < N; k++) newm[k] = (k < N - COLS) ? model[k + COLS] : 8'h00;
    start_op(1'b1, 8'h00);
    eng_cycles = 0;
    fork
      begin
        wait_done(60000);
      end
      begin
        while (BUSY) begin
          a = 11'($urandom_range(0, N - 1));
          cpu_acc(1'b0, a, 8'h00, model[a], newm[a], lat);
`ifdef VRAM_ARB_FAIR_EN
          chk("fair_cpu_wait", 32'(lat <= 7), 32'd1);
`endif
          @(posedge clk); #1;
        end
      end
      begin
        while (BUSY) begin
          @(posedge clk); #1;
          eng_cycles++;
        end
      end
    join
    $display("scroll engine cycles with CPU load: %0d", eng_cycles);
    for (int k = 0; k < 2048; k++) model[k] = newm[k];
    chk("scroll_cell0", 32'(mem[0]), 32'h50);
    chk("scroll_cell1919", 32'(mem[1919]), 32'hCF);
    chk_region("scroll_last_row", N - COLS, N - 1, 8'h00);
    chk_model("scroll_screen");
    cpu_acc(1'b0, 11'd0, 8'h00, 8'h50, 8'h50, lat);
    cpu_acc(1'b0, 11'd1919, 8'h00, 8'hCF, 8'hCF, lat);

    // RESET during FILL at index 500: abort without DONE, then restart.
    start_op(1'b0, 8'h20);
    n = 0;
    while (!(VRAM_CS && VRAM_WR && VRAM_A == 11'd500) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx500", 32'(VRAM_A), 32'd500);
    RESET = 1'b1;
    done_pending = 0;
    @(posedge clk); #1;
    RESET = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_vram_cs", 32'(VRAM_CS), 32'd0);
    chk("abort_cpu_dout", 32'(CPU_DOUT), 32'hFF);
    repeat (20) @(posedge clk);
    start_op(1'b0, 8'h33);
    wait_done(20000);
    for (int k = 0; k < N; k++) model[k] = 8'h33;
    chk_region("refill_cells", 0, N - 1, 8'h33);
    chk_model("refill_screen");
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
